// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared width, op encoding and FSM states for the HI/LO mul/div unit
package muldiv_seq_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage issue/stall handshake and HI/LO read-out of the mul/div unit
interface muldiv_seq_if #(parameter int XLEN = 32);
    logic start;
    muldiv_seq_pkg::op_e op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic rd_hilo;
    logic flush;
    logic busy;
    logic stall_req;
    logic done;
    logic div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    modport master(output start, op, op_a, op_b, rd_hilo, flush,
                   input busy, stall_req, done, div_by_zero, hi, lo);
    modport slave(input start, op, op_a, op_b, rd_hilo, flush,
                  output busy, stall_req, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply and restoring divide sharing one 2*XLEN shift register
// Multiply keeps {partial, multiplier} in p; divide keeps {remainder, dividend/quotient}.
module muldiv_datapath import muldiv_seq_pkg::*; #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  op_e             op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    logic [2*XLEN-1:0] p_q, p_d, prod;
    logic [XLEN-1:0] b_q, b_d, a_mag, b_mag, quo, rem;
    logic is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic sgn_op, a_neg, b_neg;
    logic [XLEN:0] add, shl, sub;

    always_comb begin
        sgn_op = op == OP_MULT || op == OP_DIV;
        a_neg = sgn_op & op_a[XLEN-1];
        b_neg = sgn_op & op_b[XLEN-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
        is_div_d = load ? op[1] : is_div_q;
        neg_res_d = load ? a_neg ^ b_neg : neg_res_q;
        neg_rem_d = load ? a_neg : neg_rem_q;
        b_d = load ? (op[1] ? b_mag : a_mag) : b_q;
        add = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, b_q & {XLEN{p_q[0]}}};
        shl = p_q[2*XLEN-1:XLEN-1];
        // a borrow out of the trial subtraction means the divisor did not fit
        sub = shl - {1'b0, b_q};
        p_d = load ? {{XLEN{1'b0}}, op[1] ? a_mag : b_mag}
            : !step ? p_q
            : !is_div_q ? {add, p_q[XLEN-1:1]}
            : sub[XLEN] ? {shl[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
            : {sub[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        prod = neg_res_q ? -p_d : p_d;
        quo = neg_res_q ? -p_d[XLEN-1:0] : p_d[XLEN-1:0];
        rem = neg_rem_q ? -p_d[2*XLEN-1:XLEN] : p_d[2*XLEN-1:XLEN];
        res_hi = is_div_q ? rem : prod[2*XLEN-1:XLEN];
        res_lo = is_div_q ? quo : prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            b_q <= '0;
            is_div_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            p_q <= p_d;
            b_q <= b_d;
            is_div_q <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall request
// The pre-operation HI/LO are kept so a flush in DONE can undo the write-back.
module muldiv_seq import muldiv_seq_pkg::*; #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    muldiv_seq_if.slave bus
);
    state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, hi_old_q, hi_old_d, lo_old_q, lo_old_d;
    logic [XLEN-1:0] res_hi, res_lo;
    logic dbz_q, dbz_d, accept, dz, last;

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk(clk), .rst(rst), .load(accept), .step(state_q == S_RUN),
        .op(bus.op), .op_a(bus.op_a), .op_b(bus.op_b), .res_hi(res_hi), .res_lo(res_lo)
    );

    always_comb begin
        accept = state_q == S_IDLE && bus.start && !bus.flush;
        dz = bus.op[1] && bus.op_b == '0;
        last = state_q == S_RUN && cnt_q == 6'(XLEN-1);
        state_d = state_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        hi_old_d = hi_old_q;
        lo_old_d = lo_old_q;
        dbz_d = 1'b0;
        if (bus.flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            if (state_q == S_DONE) {hi_d, lo_d} = {hi_old_q, lo_old_q};
        end else if (accept) begin
            state_d = dz ? S_DONE : S_RUN;
            cnt_d = '0;
            {hi_old_d, lo_old_d} = {hi_q, lo_q};
            if (dz) {hi_d, lo_d, dbz_d} = {bus.op_a, {XLEN{1'b1}}, 1'b1};
        end else if (last) begin
            state_d = S_DONE;
            {hi_d, lo_d} = {res_hi, res_lo};
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 6'd1;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    assign bus.busy = state_q != S_IDLE;
    assign bus.stall_req = bus.busy & (bus.start | bus.rd_hilo);
    assign bus.done = state_q == S_DONE && !bus.flush;
    assign bus.div_by_zero = dbz_q && state_q == S_DONE && !bus.flush;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            hi_old_q <= '0;
            lo_old_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            hi_old_q <= hi_old_d;
            lo_old_q <= lo_old_d;
            dbz_q <= dbz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed literal cases plus randomized traffic against a latency/arithmetic model
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0, m_dbz = 1'b0, exp_busy;
    logic [31:0] m_hi, m_lo, m_nhi, m_nlo, m_ohi, m_olo;

    muldiv_seq_if #(.XLEN(XLEN)) bus();
    muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input op_e o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o[1] && b == 0) return {a, 32'hFFFF_FFFF};
        case (o)
            OP_MULT: return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // model: result by plain arithmetic, visible XLEN+1 cycles after acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0; chk_en = 1;
        end else if ((m_left > 0 || m_done) && bus.flush) begin
            if (m_done) {m_hi, m_lo} = {m_ohi, m_olo};
            m_left = 0; m_done = 0; m_dbz = 0;
        end else if (m_done) begin
            m_done = 0; m_dbz = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                {m_hi, m_lo} = {m_nhi, m_nlo};
            end
        end else if (bus.start && !bus.flush) begin
            {m_ohi, m_olo} = {m_hi, m_lo};
            {m_nhi, m_nlo} = ref_result(bus.op, bus.op_a, bus.op_b);
            if (bus.op[1] && bus.op_b == 0) begin
                m_done = 1; m_dbz = 1;
                {m_hi, m_lo} = {m_nhi, m_nlo};
            end else m_left = XLEN;
        end
    end

    always @(negedge clk) if (chk_en) begin
        exp_busy = m_left > 0 || m_done;
        chk("busy", bus.busy, exp_busy);
        chk("stall_req", bus.stall_req, exp_busy & (bus.start | bus.rd_hilo));
        chk("done", bus.done, m_done & !bus.flush);
        chk("div_by_zero", bus.div_by_zero, m_dbz & m_done & !bus.flush);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    end

    task automatic run(input op_e o, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(posedge clk); #1;
        bus.start = 1; bus.op = o; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            lat++;
            if (lat > 40) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, nstall;
        bit saw;
        rst = 1; bus.start = 0; bus.op = OP_MULT; bus.op_a = 0; bus.op_b = 0;
        bus.rd_hilo = 0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_hi", bus.hi, 0); chk("rst_lo", bus.lo, 0); chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0); chk("rst_dbz", bus.div_by_zero, 0); chk("rst_stall", bus.stall_req, 0);

        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_lat", lat, 33); chk("multu_hi", bus.hi, 32'hFFFF_FFFE); chk("multu_lo", bus.lo, 32'h1);
        run(OP_MULT, -32'sd7, 32'd3, lat);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF); chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
        run(OP_DIV, -32'sd7, 32'd2, lat);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD); chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        run(OP_DIVU, 32'd100, 32'd7, lat);
        chk("divu_lo", bus.lo, 14); chk("divu_hi", bus.hi, 2);
        run(OP_DIVU, 32'd5, 32'd0, lat);
        chk("dz_lat", lat, 1); chk("dz_flag", bus.div_by_zero, 1);
        chk("dz_hi", bus.hi, 5); chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("ovf_lo", bus.lo, 32'h8000_0000); chk("ovf_hi", bus.hi, 0); chk("ovf_flag", bus.div_by_zero, 0);

        // MULTU 3*4 with rd_hilo held, plus an ignored second start during RUN
        @(posedge clk); #1;
        bus.start = 1; bus.op = OP_MULTU; bus.op_a = 3; bus.op_b = 4; bus.rd_hilo = 1;
        nstall = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            bus.start = k == 5;
            if (k == 5) begin bus.op = OP_DIVU; bus.op_a = 9; bus.op_b = 2; end
            @(negedge clk);
            if (k <= 33 && bus.stall_req) nstall++;
            if (k == 34) begin
                chk("rd_stall_end", bus.stall_req, 0); chk("rd_hi", bus.hi, 0); chk("rd_lo", bus.lo, 12);
            end
        end
        chk("stall_cycles", nstall, 33);
        @(posedge clk); #1 bus.rd_hilo = 0;

        // flush at T+10 of a DIV
        bus.start = 1; bus.op = OP_DIV; bus.op_a = 1000; bus.op_b = -32'sd3;
        saw = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            bus.start = 0; bus.flush = k == 10;
            @(negedge clk);
            if (bus.done) saw = 1;
            if (k == 11) chk("flush_idle", bus.busy, 0);
        end
        chk("flush_no_done", saw, 0); chk("flush_hi", bus.hi, 0); chk("flush_lo", bus.lo, 12);

        // flush beats start in IDLE
        @(posedge clk); #1 bus.start = 1; bus.flush = 1;
        @(posedge clk); #1 bus.start = 0; bus.flush = 0;
        @(negedge clk); chk("flush_start_idle", bus.busy, 0);

        // rst at T+5 of a MULTU
        @(posedge clk); #1 bus.start = 1; bus.op = OP_MULTU; bus.op_a = 5; bus.op_b = 6;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1 bus.start = 0;
        end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mrst_hi", bus.hi, 0); chk("mrst_lo", bus.lo, 0); chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0); chk("mrst_dbz", bus.div_by_zero, 0);

        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            bus.start = $urandom_range(0, 3) == 0;
            bus.op = op_e'($urandom_range(0, 3));
            bus.op_a = pick();
            bus.op_b = pick();
            bus.rd_hilo = $urandom_range(0, 1) == 1;
            bus.flush = $urandom_range(0, 40) == 0;
            rst = $urandom_range(0, 700) == 0;
        end
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 0; bus.rd_hilo = 0; rst = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and HI/LO width; only 32 is verified.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  EX stage issues a mul/div op this cycle.
REQ-005 op  in  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 op_a  in  XLEN  rs operand, already forwarded; dividend or multiplicand.
REQ-007 op_b  in  XLEN  rt operand, already forwarded; divisor or multiplier.
REQ-008 rd_hilo  in  1  MFHI or MFLO is in EX this cycle.
REQ-009 flush  in  1  EX flush; aborts the operation in progress.
REQ-010 busy  out  1  high while state is not IDLE.
REQ-011 stall_req  out  1  = busy & (start | rd_hilo); freezes IF/ID/EX.
REQ-012 done  out  1  single-cycle pulse; HI/LO hold the new result.
REQ-013 div_by_zero  out  1  pulses together with done when a divide has op_b == 0.
REQ-014 hi, lo  out  XLEN each  architectural HI/LO registers.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 Transitions SHALL be:
- IDLE -> RUN on start & ~flush;
- IDLE -> DONE on start & ~flush for a divide with op_b == 0;
- RUN -> DONE after exactly XLEN RUN cycles;
- DONE -> IDLE unconditionally.
REQ-017 On start acceptance, the block SHALL latch op and the operand magnitudes.
- Signed ops (MULT, DIV): latch |op_a| and |op_b|, plus the result sign and the dividend sign.
- Unsigned ops: latch the operands unchanged.
REQ-018 Multiply SHALL be shift-add, one multiplier bit per RUN cycle, producing a 2*XLEN product.
REQ-019 Divide SHALL be restoring, one quotient bit per RUN cycle.
REQ-020 A 6-bit counter SHALL count RUN cycles from 0 to XLEN-1 and reset to 0 on entry to RUN.
REQ-021 hi/lo SHALL be written on the edge that leaves the last RUN cycle, with sign correction applied.
- Multiply: {hi,lo} = product.
- Divide: lo = quotient, hi = remainder.
- Remainder sign SHALL equal the dividend sign.
REQ-022 done SHALL be high during the DONE cycle only. Latency is start cycle T -> done at T+XLEN+1 (T+33).
REQ-023 Divide by zero SHALL skip RUN: hi = op_a, lo = all-ones, div_by_zero = done = 1 in cycle T+1.
REQ-024 DIV of 0x8000_0000 by 0xFFFF_FFFF SHALL give lo = 0x8000_0000, hi = 0, with no flag.
REQ-025 start while busy SHALL be ignored. stall_req holds the issuing instruction until IDLE, where it is accepted.
REQ-026 flush in RUN or DONE SHALL return the FSM to IDLE at the next edge.
- hi/lo SHALL keep their pre-operation values.
- done SHALL not pulse.
REQ-027 flush and start in the same IDLE cycle: flush SHALL win and nothing starts.
REQ-028 rd_hilo in IDLE SHALL not stall. rd_hilo in DONE SHALL stall one cycle, so the reader sees the new hi/lo.
REQ-029 The ALU MUL/DIV codes SHALL no longer be issued for MULT/DIV. The decoder SHALL route fnc_code 0x18/0x19/0x1A/0x1B to this block.

Reset
REQ-030 rst SHALL force:
- state to IDLE;
- counter to 0;
- hi, lo, the working registers and sign flags to 0;
- busy, stall_req, done and div_by_zero to 0.
REQ-031 rst SHALL override start and flush, and SHALL abort a running operation, including mid-RUN.

Structure
REQ-032 A shared package SHALL hold:
- the op encoding enum (MULT/MULTU/DIV/DIVU);
- the FSM state enum;
- XLEN.
REQ-033 One sub-module, muldiv_datapath, SHALL hold the shift/add/subtract registers, controlled by the FSM in muldiv_seq.

Verification
REQ-034 MULTU 0xFFFF_FFFF * 0xFFFF_FFFF -> done at T+33; hi = 0xFFFF_FFFE, lo = 0x0000_0001.
REQ-035 MULT -7 * 3 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB.
REQ-036 DIV -7 / 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF.
REQ-036 (cont.) DIVU 100 / 7 -> lo = 14, hi = 2.
REQ-037 DIVU 5 / 0 -> T+1: done = div_by_zero = 1, hi = 5, lo = 0xFFFF_FFFF.
REQ-038 Start MULTU 3*4, then hold rd_hilo.
- stall_req SHALL be high through T+33.
- hi/lo SHALL read 0/12 in the first non-stalled cycle.
- A second start during RUN SHALL be ignored.
REQ-039 Abort cases:
- flush at T+10 of DIV -> IDLE at T+11, no done, hi/lo unchanged;
- rst at T+5 -> all outputs 0 next cycle.
